uart_rx_frame_ctrl: RTL and testbench
=====================================

# uart_rx_frame_ctrl

Receive-side frame controller for the UART receiver. It synchronises the serial line and detects the start bit. It samples each bit at mid-bit using the oversampling tick from the baud generator, and assembles the data word LSB-first. It sits directly upstream of `PARITY_CHECKER`: it hands the checker the assembled `data`, the received parity bit on `RX_data`, and a one-cycle `parity_load` strobe. It then folds the checker's `parity_bit_err` and its own stop-bit check into a validated output word.

## Interface
- `WIDTH`, 8, data bits per frame
- `OVERSAMPLE`, 16, `sample_tick` pulses per bit period; even, at least 4
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sample_tick`  in  1  oversampling enable from the baud generator, one clk wide
- `rx_in`  in  1  asynchronous serial line, idle high
- `parity_bit_err`  in  1  from `PARITY_CHECKER`, valid from the cycle after `parity_load` until the next `parity_load`
- `data`  out  `WIDTH`  assembled word, to the checker and to downstream
- `RX_data`  out  1  received parity bit, to the checker
- `parity_load`  out  1  one-cycle strobe: `data` and `RX_data` are valid
- `data_valid`  out  1  one-cycle strobe: the frame is complete
- `parity_err`  out  1  parity status of the last completed frame
- `frame_err`  out  1  stop bit was sampled low in the last completed frame
- `busy`  out  1  high in every state except IDLE

## Operation
- `rx_in` passes through a two-flop synchronizer to give `rx_s`. Both flops reset to 1.
- `cnt` counts `sample_tick`s. `bit_idx` counts data bits. `shreg` is the `WIDTH`-bit shift register.
- **IDLE**
  - On `rx_s`==0: go to START and clear `cnt`.
- **START**
  - On the tick where `cnt`==`OVERSAMPLE/2-1`:
    - If `rx_s`==1, this is a false start: return to IDLE with no strobes.
    - Otherwise clear `cnt` and `bit_idx`, and go to DATA.
- **DATA**
  - On the tick where `cnt`==`OVERSAMPLE-1`:
    - Set `shreg` <= {`rx_s`, `shreg[WIDTH-1:1]`} (LSB first).
    - Increment `bit_idx` and clear `cnt`.
  - After the `WIDTH`th bit: go to PARITY.
- **PARITY**
  - On the tick where `cnt`==`OVERSAMPLE-1`:
    - `RX_data` <= `rx_s` and `data` <= `shreg`.
    - `parity_load` is high for exactly the next clk.
  - Go to STOP.
- **STOP**
  - On the tick where `cnt`==`OVERSAMPLE-1`:
    - `frame_err` <= !`rx_s`.
    - `parity_err` <= `parity_bit_err`.
    - `data_valid` is high for exactly the next clk.
  - Go to IDLE.
  - Because the controller leaves STOP at mid-stop-bit, a start bit that immediately follows is still detected.
- `data` and `RX_data` hold from `parity_load` until the next frame's `parity_load`.
- `parity_err` and `frame_err` update only together with `data_valid`, and hold until the next `data_valid`.
- Counters advance only on `sample_tick`. With no ticks, the state is frozen, apart from the synchronizer and from IDLE start detection.

## Timing
- **Reset values:**
  - `data`=0, `RX_data`=0, `parity_load`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
  - State is IDLE, `cnt`=0, `bit_idx`=0, `shreg`=0.
- **Reset mid-frame:** the next clk yields all of the reset values above. No strobe is emitted for the aborted frame.
- **Latency with `sample_tick` high every clk:**
  - Edge k is the first clk edge that samples `rx_in` low.
  - START is entered at edge k+3.
  - Data bit j is captured on tick 8+16(j+1) after START entry.
  - `parity_load` is high after tick 8+16·(`WIDTH`+1).
  - `data_valid` is high after tick 8+16·(`WIDTH`+2). For `WIDTH`=8 this is 171 clk after k.
- **Strobe overlap:** `parity_load` and `data_valid` never coincide. `parity_load` precedes `data_valid` by `OVERSAMPLE` ticks.
- **No back-pressure:** the downstream consumer must capture the word on `data_valid`.
- **Overrun:** a new frame overwrites `data` at its own `parity_load`.

## Structure
- **Package `uart_rx_pkg`:**
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Default `WIDTH` and `OVERSAMPLE`.
  - Counter width constants: $clog2(`OVERSAMPLE`) and $clog2(`WIDTH`+1).
- **Sub-module `rx_sync`:** the two-flop synchronizer, reset value 1. Everything else lives in the FSM module.

## Test plan
- **Nominal frame:** `WIDTH`=8, `OVERSAMPLE`=16, tick every clk. Send 0xA5 with parity bit 0 and stop bit 1. The bench parity model is even parity and drives `parity_bit_err`=0.
  - Expect one `parity_load` with `data`=0xA5 and `RX_data`=0.
  - Expect `data_valid` 171 clk after the start edge, with `data`=0xA5, `parity_err`=0, `frame_err`=0.
- **Parity error:** send 0x3C with parity bit 1; the model drives `parity_bit_err`=1.
  - Expect `data_valid` with `parity_err`=1 and `frame_err`=0.
- **Framing error:** send 0xFF with correct parity and stop bit 0.
  - Expect `frame_err`=1.
  - A following 0x01 frame must still be received correctly.
- **False start:** pulse `rx_in` low for 4 clk.
  - Expect a return to IDLE.
  - Expect no `parity_load` or `data_valid`, and `busy` low again within 12 clk.
- **Reset mid-frame:** assert `rst` during bit 4 of a frame.
  - Expect all outputs at reset values on the next clk.
  - Expect no strobes.
  - The next full frame, 0x5A, must be received correctly.
- **Sparse ticks:** `sample_tick` high one clk in four.
  - Send back-to-back frames 0x12 and 0x34.
  - Expect both `data_valid` strobes with the correct data.
  - The strobes must be 4·16·11 clk apart.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and sizing helpers for the UART receive frame controller.
package uart_rx_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Width of the sample_tick counter (counts 0 .. OVERSAMPLE-1).
  function automatic int unsigned cnt_width(input int unsigned oversample);
    return $clog2(oversample);
  endfunction

  // Width of the data bit counter (counts 0 .. WIDTH).
  function automatic int unsigned idx_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous serial line; idles high.
module rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the line; reset to the idle (high) level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, mid-bit sampling,
// LSB-first assembly, hand-off to the parity checker, stop-bit check.
//
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | validating start bit at its middle
//   DATA   | sampling WIDTH data bits at mid-bit
//   PARITY | sampling parity bit, loading checker
//   STOP   | sampling stop bit, publishing status
module uart_rx_frame_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sample_tick,
  input  logic             i_rx_in,
  input  logic             i_parity_bit_err,
  output logic [WIDTH-1:0] o_data,
  output logic             o_RX_data,
  output logic             o_parity_load,
  output logic             o_data_valid,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_busy
);

  localparam int unsigned CNT_W = cnt_width(OVERSAMPLE);
  localparam int unsigned IDX_W = idx_width(WIDTH);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  logic               w_rx_s;
  logic               r_rx_smp;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   r_data;
  logic               r_rx_data;
  logic               r_parity_load;
  logic               r_data_valid;
  logic               r_parity_err;
  logic               r_frame_err;

  logic               w_tick_mid;
  logic               w_tick_end;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_idx_clr;
  logic               w_shift;
  logic               w_load;
  logic               w_done;
  logic               w_busy;

  rx_sync u_rx_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx_in),
    .o_q   (w_rx_s)
  );

  // Sampling register on the synchronised line; with it the start edge
  // reaches START three clocks after capture, which centres every later
  // sample on its bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rx_smp <= 1'b1;
    else       r_rx_smp <= w_rx_s;
  end

  assign w_tick_mid = i_sample_tick && (r_cnt == CNT_MID);
  assign w_tick_end = i_sample_tick && (r_cnt == CNT_END);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decision; counters only move states on sample ticks.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!r_rx_smp)  w_state_nxt = ST_START;
      ST_START:  if (w_tick_mid) w_state_nxt = r_rx_smp ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_tick_end && (r_bit_idx == IDX_LAST)) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_tick_end) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_tick_end) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state datapath controls.
  always_comb begin
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_idx_clr = 1'b0;
    w_shift   = 1'b0;
    w_load    = 1'b0;
    w_done    = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy    = 1'b0;
        w_cnt_clr = !r_rx_smp;
      end
      ST_START: begin
        w_cnt_clr = w_tick_mid;
        w_idx_clr = w_tick_mid;
        w_cnt_inc = i_sample_tick;
      end
      ST_DATA: begin
        w_cnt_clr = w_tick_end;
        w_shift   = w_tick_end;
        w_cnt_inc = i_sample_tick;
      end
      ST_PARITY: begin
        w_cnt_clr = w_tick_end;
        w_load    = w_tick_end;
        w_cnt_inc = i_sample_tick;
      end
      ST_STOP: begin
        w_cnt_clr = w_tick_end;
        w_done    = w_tick_end;
        w_cnt_inc = i_sample_tick;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // Counters, shift register, checker hand-off and frame status.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_bit_idx     <= '0;
      r_shreg       <= '0;
      r_data        <= '0;
      r_rx_data     <= 1'b0;
      r_parity_load <= 1'b0;
      r_data_valid  <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_parity_load <= w_load;
      r_data_valid  <= w_done;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_idx_clr)      r_bit_idx <= '0;
      else if (w_shift)   r_bit_idx <= r_bit_idx + IDX_W'(1);
      if (w_shift)        r_shreg <= {r_rx_smp, r_shreg[WIDTH-1:1]};
      if (w_load) begin
        r_data    <= r_shreg;
        r_rx_data <= r_rx_smp;
      end
      if (w_done) begin
        r_frame_err  <= !r_rx_smp;
        r_parity_err <= i_parity_bit_err;
      end
    end
  end

  assign o_data        = r_data;
  assign o_RX_data     = r_rx_data;
  assign o_parity_load = r_parity_load;
  assign o_data_valid  = r_data_valid;
  assign o_parity_err  = r_parity_err;
  assign o_frame_err   = r_frame_err;
  assign o_busy        = w_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized frame bench for uart_rx_frame_ctrl.
module tb_uart_rx_frame_ctrl;

  localparam int W  = 8;
  localparam int OS = 16;

  typedef struct { logic [W-1:0] d; logic b; int c; } pl_t;
  typedef struct { logic [W-1:0] d; logic pe; logic fe; int c; } dv_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b1;
  logic         rx = 1'b1;
  logic         perr_in = 1'b0;
  logic [W-1:0] data;
  logic         rx_data, parity_load, data_valid, parity_err, frame_err, busy;

  int cyc = 0;
  int tick_div = 1;
  int checks = 0;
  int failures = 0;
  int overlap_cnt = 0;
  pl_t pl_q[$];
  dv_t dv_q[$];

  uart_rx_frame_ctrl #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_sample_tick    (tick),
    .i_rx_in          (rx),
    .i_parity_bit_err (perr_in),
    .o_data           (data),
    .o_RX_data        (rx_data),
    .o_parity_load    (parity_load),
    .o_data_valid     (data_valid),
    .o_parity_err     (parity_err),
    .o_frame_err      (frame_err),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Baud tick: every clk, or one clk in tick_div.
  always @(negedge clk) tick = (tick_div == 1) || ((cyc % tick_div) == 0);

  // Even-parity checker model standing in for PARITY_CHECKER.
  always @(negedge clk) if (parity_load) perr_in = ^{data, rx_data};

  // Strobe recorder.
  always @(negedge clk) begin
    if (parity_load) pl_q.push_back('{d: data, b: rx_data, c: cyc});
    if (data_valid)  dv_q.push_back('{d: data, pe: parity_err, fe: frame_err, c: cyc});
    if (parity_load && data_valid) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; caller is at a negedge. k is the first edge seeing start.
  task automatic send_frame(input logic [W-1:0] d, input logic pb, input logic sb, output int k);
    logic [W+2:0] bits;
    bits = {sb, pb, d, 1'b0};
    k = cyc + 1;
    for (int i = 0; i < W + 3; i++) begin
      rx = bits[i];
      repeat (OS * tick_div) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Compare the recorded strobes of one frame against the frame's own rules.
  task automatic expect_frame(input string tag, input logic [W-1:0] d, input logic pb,
                              input logic sb, input int k, input bit chk_lat, output int dv_c);
    pl_t p;
    dv_t v;
    dv_c = -1;
    check({tag, "_pl_count"}, pl_q.size(), 1);
    check({tag, "_dv_count"}, dv_q.size(), 1);
    if (pl_q.size() > 0 && dv_q.size() > 0) begin
      p = pl_q.pop_front();
      v = dv_q.pop_front();
      dv_c = v.c;
      check({tag, "_pl_data"}, p.d, d);
      check({tag, "_pl_rxdata"}, p.b, pb);
      check({tag, "_dv_data"}, v.d, d);
      check({tag, "_parity_err"}, v.pe, (^d) ^ pb);
      check({tag, "_frame_err"}, v.fe, !sb);
      check({tag, "_pl_to_dv"}, v.c - p.c, OS * tick_div);
      if (chk_lat) check({tag, "_latency"}, v.c - k, 8 + OS * (W + 2) + 3);
    end
    pl_q.delete();
    dv_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, data, 0);
    check({tag, "_rxdata"}, rx_data, 0);
    check({tag, "_pl"}, parity_load, 0);
    check({tag, "_dv"}, data_valid, 0);
    check({tag, "_perr"}, parity_err, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int k, k2, c1, c2;
    logic [W-1:0] rd;
    logic rp, rs;

    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal frame.
    send_frame(8'hA5, 1'b0, 1'b1, k);
    expect_frame("nominal", 8'hA5, 1'b0, 1'b1, k, 1'b1, c1);
    repeat (5) @(negedge clk);

    // Parity error.
    send_frame(8'h3C, 1'b1, 1'b1, k);
    expect_frame("parity", 8'h3C, 1'b1, 1'b1, k, 1'b1, c1);
    repeat (5) @(negedge clk);

    // Framing error, then a good frame.
    send_frame(8'hFF, 1'b0, 1'b0, k);
    expect_frame("framing", 8'hFF, 1'b0, 1'b0, k, 1'b1, c1);
    repeat (30) @(negedge clk);
    send_frame(8'h01, 1'b1, 1'b1, k);
    expect_frame("after_ferr", 8'h01, 1'b1, 1'b1, k, 1'b1, c1);
    repeat (5) @(negedge clk);

    // False start.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("false_start_busy_high", busy, 1);
    repeat (6) @(negedge clk);
    check("false_start_busy_low", busy, 0);
    repeat (200) @(negedge clk);
    check("false_start_no_pl", pl_q.size(), 0);
    check("false_start_no_dv", dv_q.size(), 0);

    // Randomized frames, back-to-back when the stop bit is good.
    for (int n = 0; n < 8; n++) begin
      rd = W'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rs, k);
      expect_frame($sformatf("rand%0d", n), rd, rp, rs, k, 1'b1, c1);
      repeat (rs ? $urandom_range(0, 20) : $urandom_range(20, 40)) @(negedge clk);
    end

    // Leave error flags set so the reset check below is meaningful.
    send_frame(8'h77, 1'b1, 1'b0, k);
    expect_frame("pre_reset", 8'h77, 1'b1, 1'b0, k, 1'b1, c1);
    repeat (30) @(negedge clk);

    // Reset during data bit 4.
    rd = 8'hC3;
    rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = rd[i];
      repeat (OS) @(negedge clk);
    end
    rx = rd[4];
    repeat (OS / 2) @(negedge clk);
    check("midframe_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    rst = 1'b0;
    rx = 1'b1;
    repeat (250) @(negedge clk);
    check("abort_no_pl", pl_q.size(), 0);
    check("abort_no_dv", dv_q.size(), 0);
    send_frame(8'h5A, 1'b0, 1'b1, k);
    expect_frame("after_reset", 8'h5A, 1'b0, 1'b1, k, 1'b1, c1);
    repeat (5) @(negedge clk);

    // Sparse ticks, back-to-back frames.
    tick_div = 4;
    repeat (8) @(negedge clk);
    send_frame(8'h12, 1'b0, 1'b1, k);
    send_frame(8'h34, 1'b1, 1'b1, k2);
    repeat (10) @(negedge clk);
    check("sparse_pl_count", pl_q.size(), 2);
    check("sparse_dv_count", dv_q.size(), 2);
    if (pl_q.size() == 2 && dv_q.size() == 2) begin
      pl_t p0, p1;
      dv_t v0, v1;
      p0 = pl_q.pop_front(); p1 = pl_q.pop_front();
      v0 = dv_q.pop_front(); v1 = dv_q.pop_front();
      check("sparse_d0", v0.d, 8'h12);
      check("sparse_d1", v1.d, 8'h34);
      check("sparse_pl_d0", p0.d, 8'h12);
      check("sparse_pl_d1", p1.d, 8'h34);
      check("sparse_perr0", v0.pe, 0);
      check("sparse_perr1", v1.pe, 0);
      check("sparse_spacing", v1.c - v0.c, 4 * OS * (W + 3));
    end
    pl_q.delete();
    dv_q.delete();

    check("strobe_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
